// File: rtl/rf_arb_pkg.sv
// Shared types and default sizing for the register-file port arbiter.
package rf_arb_pkg;

  localparam int NREQ_DEF     = 3;
  localparam int DATA_W_DEF   = 26;
  localparam int ADDR_W_DEF   = 5;
  localparam int NUM_REGS_DEF = 13;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  // In-flight operation at the default sizing; the arbiter keeps its own
  // copy sized from its parameters.
  typedef struct packed {
    logic                  we;
    logic [ADDR_W_DEF-1:0] addr_a;
    logic [ADDR_W_DEF-1:0] addr_b;
    logic [DATA_W_DEF-1:0] wdata;
    logic [1:0]            id;
    logic                  err;
  } op_t;

endpackage

// File: rtl/rf_port_arbiter_if.sv
// Requester-side bus of the register-file port arbiter.
interface rf_port_arbiter_if
  import rf_arb_pkg::*;
#(
  parameter int NREQ   = NREQ_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);
  localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]             req_valid;
  logic [NREQ-1:0]             req_we;
  logic [NREQ-1:0][ADDR_W-1:0] req_addr_a;
  logic [NREQ-1:0][ADDR_W-1:0] req_addr_b;
  logic [NREQ-1:0][DATA_W-1:0] req_wdata;
  logic [NREQ-1:0]             req_ready;
  logic                        resp_valid;
  logic [ID_W-1:0]             resp_id;
  logic                        resp_err;
  logic [DATA_W-1:0]           resp_rd1;
  logic [DATA_W-1:0]           resp_rd2;

  modport master (
    output req_valid, req_we, req_addr_a, req_addr_b, req_wdata,
    input  req_ready, resp_valid, resp_id, resp_err, resp_rd1, resp_rd2
  );

  modport slave (
    input  req_valid, req_we, req_addr_a, req_addr_b, req_wdata,
    output req_ready, resp_valid, resp_id, resp_err, resp_rd1, resp_rd2
  );
endinterface

// File: rtl/rf_port_arbiter_rr_arbiter.sv
// Round-robin grant selection; the pointer advances past the winner on enable.
module rr_arbiter #(
  parameter  int NREQ = 3,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_id
);
  localparam int unsigned N = NREQ;

  logic [IW-1:0] ptr;

  // First requester found searching upward from ptr with wrap-around.
  always_comb begin
    int unsigned idx;
    logic        found;
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(ptr) + k) % N;
      if (!found && req[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        grant_id    = IW'(idx);
      end
    end
  end

  // Pointer moves to the requester after the one just granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (en && (|req)) begin
      ptr <= (32'(grant_id) == N - 1) ? '0 : grant_id + 1'b1;
    end
  end
endmodule

// File: rtl/rf_port_arbiter.sv
// Shares one register-file port among NREQ requesters, one op per 3 cycles.
module rf_port_arbiter
  import rf_arb_pkg::*;
#(
  parameter int NREQ     = NREQ_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  rf_port_arbiter_if.slave        bus,
  output logic                    we_RF,
  output logic [ADDR_W-1:0]       A1,
  output logic [ADDR_W-1:0]       A2,
  output logic [ADDR_W-1:0]       A3,
  output logic [DATA_W-1:0]       WD3,
  input  logic [DATA_W-1:0]       RD1,
  input  logic [DATA_W-1:0]       RD2
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [ADDR_W:0] LIM = (ADDR_W + 1)'(NUM_REGS);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic [DATA_W-1:0] wdata;
    logic [IW-1:0]     id;
    logic              err;
  } op_r_t;

  function automatic logic out_of_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} >= LIM;
  endfunction

  state_t          state, state_nx;
  op_r_t           op;
  logic            accept;
  logic [NREQ-1:0] grant;
  logic [IW-1:0]   gid;

  assign accept = (state == IDLE) && !rst && (|bus.req_valid);

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .clk      (clk),
    .rst      (rst),
    .req      (bus.req_valid),
    .en       (accept),
    .grant    (grant),
    .grant_id (gid)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Sequencer: accept, drive the bank, respond, then back to idle.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = ACCESS;
      ACCESS:  state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Capture the granted request and its range check at acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      op <= '0;
    end else if (accept) begin
      op.we     <= bus.req_we[gid];
      op.addr_a <= bus.req_addr_a[gid];
      op.addr_b <= bus.req_addr_b[gid];
      op.wdata  <= bus.req_wdata[gid];
      op.id     <= gid;
      op.err    <= bus.req_we[gid] ? out_of_range(bus.req_addr_a[gid])
                                   : (out_of_range(bus.req_addr_a[gid]) ||
                                      out_of_range(bus.req_addr_b[gid]));
    end
  end

  // Outputs decoded from state; everything idles at zero outside its phase.
  always_comb begin
    bus.req_ready  = accept ? grant : '0;
    bus.resp_valid = 1'b0;
    bus.resp_id    = '0;
    bus.resp_err   = 1'b0;
    bus.resp_rd1   = '0;
    bus.resp_rd2   = '0;
    we_RF          = 1'b0;
    A1             = '0;
    A2             = '0;
    A3             = '0;
    WD3            = '0;
    case (state)
      ACCESS: begin
        if (!op.err) begin
          if (op.we) begin
            we_RF = 1'b1;
            A3    = op.addr_a;
            WD3   = op.wdata;
          end else begin
            A1 = op.addr_a;
            A2 = op.addr_b;
          end
        end
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_id    = op.id;
        bus.resp_err   = op.err;
        if (!op.we && !op.err) begin
          bus.resp_rd1 = RD1;
          bus.resp_rd2 = RD2;
        end
      end
      default: ;
    endcase
  end
endmodule
